// File: rtl/register_file_pkg.sv
// Shared processor constants: datapath width, register address type and register indices.
package register_file_pkg;

  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned REG_ADDR_WIDTH = 3;

  // Register address type, shared by decode and hazard logic.
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t R0 = 3'd0;
  localparam reg_addr_t R1 = 3'd1;
  localparam reg_addr_t R2 = 3'd2;
  localparam reg_addr_t R3 = 3'd3;
  localparam reg_addr_t R4 = 3'd4;
  localparam reg_addr_t R5 = 3'd5;
  localparam reg_addr_t R6 = 3'd6;
  localparam reg_addr_t R7 = 3'd7;

endpackage

// File: rtl/register_read_port.sv
// One combinational read port: storage select, same-cycle write bypass and zero-register override.
module register_read_port #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                                          rst_n,
  input  logic                                          write_en,
  input  logic [ADDR_WIDTH-1:0]                         write_addr,
  input  logic [DATA_WIDTH-1:0]                         write_data,
  input  logic [(1 << ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  regs,
  input  logic [ADDR_WIDTH-1:0]                         read_addr,
  output logic [DATA_WIDTH-1:0]                         read_data
);

  import register_file_pkg::*;

  logic is_zero_reg;
  logic bypass_hit;

  assign is_zero_reg = ZERO_REG && (read_addr == ADDR_WIDTH'(R0));
  // Bypass is suppressed in reset so reads stay at zero while rst_n is low.
  assign bypass_hit  = BYPASS && rst_n && write_en && (write_addr == read_addr);

  // Select stored value, override with in-flight write data, then force zero where required.
  always_comb begin
    read_data = regs[read_addr];
    if (bypass_hit) begin
      read_data = write_data;
    end
    if (!rst_n || is_zero_reg) begin
      read_data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 8 x 16 general-purpose register file: two combinational read ports, one synchronous write port.
module register_file #(
  parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  import register_file_pkg::*;

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic [NumRegs-1:0][DATA_WIDTH-1:0] regs_q;
  logic                               write_active;

  // Writes to the hardwired zero register are dropped so its storage never changes.
  assign write_active = write_en && !(ZERO_REG && (write_addr == ADDR_WIDTH'(R0)));

  // Register storage: async clear, single write per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (write_active) begin
      regs_q[write_addr] <= write_data;
    end
  end

  register_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS),
    .ZERO_REG   (ZERO_REG)
  ) u_read_port1 (
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .regs       (regs_q),
    .read_addr  (read_addr1),
    .read_data  (read_data1)
  );

  register_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS),
    .ZERO_REG   (ZERO_REG)
  ) u_read_port2 (
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .regs       (regs_q),
    .read_addr  (read_addr2),
    .read_data  (read_data2)
  );

endmodule
